// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-slot alarm engine.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } slot_state_t;

  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
  localparam logic [7:0] BCD_MS_MAX   = 8'h59;

  // True when both BCD digits are decimal and the value does not exceed max_val.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max_val);
    return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max_val);
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: stored BCD time, weekday mask, ring/snooze FSM and seconds
// counter. Optional snooze cap enabled by ALARM_SNOOZE_CAP_EN.
module alarm_slot
  import alarm_pkg::*;
#(
  parameter int CNT_W      = 9,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk1sec,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [2:0] week,
  input  logic       wr_stb,
  input  logic [7:0] wr_hour,
  input  logic [7:0] wr_min,
  input  logic [7:0] wr_sec,
  input  logic [6:0] wr_wmask,
  input  logic       wr_arm,
  input  logic       ack_edge,
  input  logic       snooze_edge,
  output logic       ringing,
  output logic       snoozed
);

  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  if (MAX_SNOOZE < 1) begin : g_bad_cap
    $error("alarm_slot: MAX_SNOOZE must be at least 1");
  end

  slot_state_t      state;
  logic [7:0]       a_hour;
  logic [7:0]       a_min;
  logic [7:0]       a_sec;
  logic [6:0]       wmask;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       wmask_ext;
  logic             match;
  logic             cap_hit;

  // Week value 7 indexes the zero pad bit, so it never matches.
  assign wmask_ext = {1'b0, wmask};
  assign match     = clk1sec && (hour == a_hour) && (min == a_min) &&
                     (sec == a_sec) && wmask_ext[week];

`ifdef ALARM_SNOOZE_CAP_EN
  localparam int SC_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

  logic [SC_W-1:0] snz_cnt;
  logic            snooze_take;
  logic            dismiss;
  logic            ring_timeout;

  // Count events mirror the FSM priority: write > ack > snooze > tick.
  assign snooze_take  = (state == RINGING) && !ack_edge && snooze_edge;
  assign cap_hit      = snooze_take && (snz_cnt == SC_W'(MAX_SNOOZE));
  assign dismiss      = ((state == RINGING) || (state == SNOOZED)) && ack_edge;
  assign ring_timeout = (state == RINGING) && !ack_edge && !snooze_edge &&
                        clk1sec && (cnt == CNT_LAST);

  // Snooze count: cleared on write, dismiss, cap and timeout; bumped per snooze.
  always_ff @(posedge clk) begin
    if (!rst || wr_stb || dismiss || cap_hit || ring_timeout) begin
      snz_cnt <= '0;
    end else if (snooze_take) begin
      snz_cnt <= snz_cnt + 1'b1;
    end
  end
`else
  assign cap_hit = 1'b0;
`endif

  // Slot FSM: write wins, then ack, then snooze, then the 1 Hz countdown.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      a_hour <= '0;
      a_min  <= '0;
      a_sec  <= '0;
      wmask  <= '0;
      cnt    <= '0;
    end else if (wr_stb) begin
      a_hour <= wr_hour;
      a_min  <= wr_min;
      a_sec  <= wr_sec;
      wmask  <= wr_wmask;
      cnt    <= '0;
      state  <= wr_arm ? ARMED : IDLE;
    end else begin
      case (state)
        IDLE: ;
        ARMED: begin
          if (match) begin
            state <= RINGING;
            cnt   <= RING_LD;
          end
        end
        RINGING: begin
          if (ack_edge || cap_hit) begin
            state <= ARMED;
            cnt   <= '0;
          end else if (snooze_edge) begin
            state <= SNOOZED;
            cnt   <= SNOOZE_LD;
          end else if (clk1sec) begin
            if (cnt == CNT_LAST) begin
              state <= ARMED;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        SNOOZED: begin
          if (ack_edge) begin
            state <= ARMED;
            cnt   <= '0;
          end else if (clk1sec) begin
            if (cnt == CNT_LAST) begin
              state <= RINGING;
              cnt   <= RING_LD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign ringing = (state == RINGING);
  assign snoozed = (state == SNOOZED);

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot BCD alarm engine: edge detection on ack/snooze, write
// validation, slot decode and lowest-index ring priority encoder.
// Optional snooze cap: define ALARM_SNOOZE_CAP_EN.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int CNT_W      = 9,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk1sec,
  input  logic [7:0]            hour,
  input  logic [7:0]            min,
  input  logic [7:0]            sec,
  input  logic [2:0]            week,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [7:0]            wr_hour,
  input  logic [7:0]            wr_min,
  input  logic [7:0]            wr_sec,
  input  logic [6:0]            wr_wmask,
  input  logic                  wr_arm,
  input  logic                  ack,
  input  logic                  snooze,
  output logic                  wr_err,
  output logic [NUM_ALARMS-1:0] ring_vec,
  output logic                  ring,
  output logic [IDX_W-1:0]      ring_idx,
  output logic [NUM_ALARMS-1:0] snoozed_vec
);

  if ((NUM_ALARMS < 1) || (NUM_ALARMS > 8) || ((2 ** IDX_W) < NUM_ALARMS)) begin : g_bad_idx
    $error("alarm_bank: NUM_ALARMS must be 1..8 and fit in IDX_W bits");
  end
  if ((RING_SEC >= (2 ** CNT_W)) || (SNOOZE_SEC >= (2 ** CNT_W))) begin : g_bad_cnt
    $error("alarm_bank: CNT_W too narrow for RING_SEC/SNOOZE_SEC");
  end

  logic ack_q;
  logic snooze_q;
  logic ack_edge;
  logic snooze_edge;
  logic wr_valid;

  assign ack_edge    = ack & ~ack_q;
  assign snooze_edge = snooze & ~snooze_q;

  assign wr_valid = bcd_valid(wr_hour, BCD_HOUR_MAX) &&
                    bcd_valid(wr_min, BCD_MS_MAX) &&
                    bcd_valid(wr_sec, BCD_MS_MAX) &&
                    (32'(wr_idx) < NUM_ALARMS);

  // Button history for edge detection and the registered reject pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q    <= 1'b0;
      snooze_q <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      ack_q    <= ack;
      snooze_q <= snooze;
      wr_err   <= wr_en && !wr_valid;
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    alarm_slot #(
      .CNT_W      (CNT_W),
      .RING_SEC   (RING_SEC),
      .SNOOZE_SEC (SNOOZE_SEC),
      .MAX_SNOOZE (MAX_SNOOZE)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .clk1sec     (clk1sec),
      .hour        (hour),
      .min         (min),
      .sec         (sec),
      .week        (week),
      .wr_stb      (wr_en && wr_valid && (wr_idx == IDX_W'(i))),
      .wr_hour     (wr_hour),
      .wr_min      (wr_min),
      .wr_sec      (wr_sec),
      .wr_wmask    (wr_wmask),
      .wr_arm      (wr_arm),
      .ack_edge    (ack_edge),
      .snooze_edge (snooze_edge),
      .ringing     (ring_vec[i]),
      .snoozed     (snoozed_vec[i])
    );
  end

  assign ring = |ring_vec;

  // Lowest-index ringing slot; 0 when nothing rings.
  always_comb begin
    logic found;
    ring_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (ring_vec[i] && !found) begin
        ring_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: expected outputs are queued as stimulus
// is applied and compared one clock later.
module tb_alarm_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk1sec;
  logic [7:0] hour, min, sec;
  logic [2:0] week;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [7:0] wr_hour, wr_min, wr_sec;
  logic [6:0] wr_wmask;
  logic       wr_arm;
  logic       ack, snooze;
  logic       wr_err;
  logic [3:0] ring_vec;
  logic       ring;
  logic [1:0] ring_idx;
  logic [3:0] snoozed_vec;

  alarm_bank #(
    .NUM_ALARMS (4),
    .IDX_W      (2),
    .RING_SEC   (60),
    .SNOOZE_SEC (300),
    .CNT_W      (9),
    .MAX_SNOOZE (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk1sec     (clk1sec),
    .hour        (hour),
    .min         (min),
    .sec         (sec),
    .week        (week),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_hour     (wr_hour),
    .wr_min      (wr_min),
    .wr_sec      (wr_sec),
    .wr_wmask    (wr_wmask),
    .wr_arm      (wr_arm),
    .ack         (ack),
    .snooze      (snooze),
    .wr_err      (wr_err),
    .ring_vec    (ring_vec),
    .ring        (ring),
    .ring_idx    (ring_idx),
    .snoozed_vec (snoozed_vec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] vec;
    logic [3:0] snz;
    logic [1:0] idx;
    logic       err;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];
  exp_t  cur;
  string cur_tag;
  int    checks = 0;
  int    failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue what the outputs must show after the next rising edge.
  task automatic expect_out(input string tag, input logic [3:0] vec, input logic [3:0] snz,
                            input logic [1:0] idx, input logic err);
    exp_t e;
    e.vec = vec;
    e.snz = snz;
    e.idx = idx;
    e.err = err;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      cur     = sb.pop_front();
      cur_tag = tag_q.pop_front();
      check_eq({cur_tag, "/ring_vec"}, 32'(ring_vec), 32'(cur.vec));
      check_eq({cur_tag, "/ring"}, 32'(ring), 32'(cur.vec != 4'b0));
      check_eq({cur_tag, "/ring_idx"}, 32'(ring_idx), 32'(cur.idx));
      check_eq({cur_tag, "/snoozed_vec"}, 32'(snoozed_vec), 32'(cur.snz));
      check_eq({cur_tag, "/wr_err"}, 32'(wr_err), 32'(cur.err));
    end
  end

  task automatic tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                      input logic [2:0] w);
    @(negedge clk);
    wr_en = 1'b0; hour = h; min = m; sec = s; week = w; clk1sec = 1'b1;
  endtask

  task automatic tick_ack(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic [2:0] w);
    @(negedge clk);
    wr_en = 1'b0; ack = 1'b1; hour = h; min = m; sec = s; week = w; clk1sec = 1'b1;
  endtask

  task automatic write(input logic [1:0] idx, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input logic [6:0] mask, input logic arm);
    @(negedge clk);
    clk1sec = 1'b0; wr_en = 1'b1; wr_idx = idx;
    wr_hour = h; wr_min = m; wr_sec = s; wr_wmask = mask; wr_arm = arm;
  endtask

  task automatic set_btn(input logic a, input logic s);
    @(negedge clk);
    clk1sec = 1'b0; wr_en = 1'b0; ack = a; snooze = s;
  endtask

  task automatic idle();
    @(negedge clk);
    clk1sec = 1'b0; wr_en = 1'b0;
  endtask

  // Filler ticks at a time no slot is ever set to.
  task automatic quiet_tick();
    tick(8'h01, 8'h00, 8'h00, 3'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clk1sec = 1'b0; hour = '0; min = '0; sec = '0; week = '0;
    wr_en = 1'b0; wr_idx = '0; wr_hour = '0; wr_min = '0; wr_sec = '0;
    wr_wmask = '0; wr_arm = 1'b0; ack = 1'b0; snooze = 1'b0;

    @(negedge clk);
    expect_out("reset", 4'b0000, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single alarm on slot 2, full ring timeout, next-day re-ring.
    write(2'd2, 8'h07, 8'h30, 8'h00, 7'h7F, 1'b1);
    expect_out("wr_ok", 4'b0000, 4'b0000, 2'd0, 1'b0);
    tick(8'h07, 8'h29, 8'h59, 3'd1);
    expect_out("pre_match", 4'b0000, 4'b0000, 2'd0, 1'b0);
    tick(8'h07, 8'h30, 8'h00, 3'd1);
    expect_out("match", 4'b0100, 4'b0000, 2'd2, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      quiet_tick();
      if (i == 59) expect_out("ring_hold59", 4'b0100, 4'b0000, 2'd2, 1'b0);
      if (i == 60) expect_out("ring_timeout", 4'b0000, 4'b0000, 2'd0, 1'b0);
    end
    tick(8'h07, 8'h30, 8'h00, 3'd2);
    expect_out("next_day", 4'b0100, 4'b0000, 2'd2, 1'b0);
    set_btn(1'b1, 1'b0);
    expect_out("ack_dismiss", 4'b0000, 4'b0000, 2'd0, 1'b0);
    set_btn(1'b0, 1'b0);

    // Two slots ringing together, snooze, expiry, ack+snooze collision.
    write(2'd0, 8'h12, 8'h00, 8'h00, 7'h7F, 1'b1);
    write(2'd3, 8'h12, 8'h00, 8'h00, 7'h7F, 1'b1);
    tick(8'h12, 8'h00, 8'h00, 3'd0);
    expect_out("multi_ring", 4'b1001, 4'b0000, 2'd0, 1'b0);
    set_btn(1'b0, 1'b1);
    expect_out("snooze", 4'b0000, 4'b1001, 2'd0, 1'b0);
    set_btn(1'b0, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      quiet_tick();
      if (i == 299) expect_out("snz_hold299", 4'b0000, 4'b1001, 2'd0, 1'b0);
      if (i == 300) expect_out("snz_expire", 4'b1001, 4'b0000, 2'd0, 1'b0);
    end
    set_btn(1'b1, 1'b1);
    expect_out("ack_beats_snz", 4'b0000, 4'b0000, 2'd0, 1'b0);
    set_btn(1'b0, 1'b0);
    tick(8'h12, 8'h00, 8'h00, 3'd0);
    expect_out("still_armed", 4'b1001, 4'b0000, 2'd0, 1'b0);
    tick_ack(8'h12, 8'h00, 8'h00, 3'd0);
    expect_out("ack_no_rematch", 4'b0000, 4'b0000, 2'd0, 1'b0);
    set_btn(1'b0, 1'b0);
    expect_out("ack_no_rematch2", 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Write validation and weekday mask.
    write(2'd1, 8'h06, 8'h15, 8'h00, 7'h7F, 1'b1);
    expect_out("wr_slot1", 4'b0000, 4'b0000, 2'd0, 1'b0);
    write(2'd1, 8'h24, 8'h15, 8'h00, 7'h7F, 1'b1);
    expect_out("err_hour", 4'b0000, 4'b0000, 2'd0, 1'b1);
    idle();
    expect_out("err_pulse_end", 4'b0000, 4'b0000, 2'd0, 1'b0);
    write(2'd1, 8'h06, 8'h5A, 8'h00, 7'h7F, 1'b1);
    expect_out("err_min", 4'b0000, 4'b0000, 2'd0, 1'b1);
    write(2'd1, 8'h06, 8'h15, 8'h1A, 7'h7F, 1'b0);
    expect_out("err_digit", 4'b0000, 4'b0000, 2'd0, 1'b1);
    idle();
    tick(8'h06, 8'h15, 8'h00, 3'd4);
    expect_out("unchanged_ring", 4'b0010, 4'b0000, 2'd1, 1'b0);
    set_btn(1'b1, 1'b0);
    expect_out("ack_slot1", 4'b0000, 4'b0000, 2'd0, 1'b0);
    set_btn(1'b0, 1'b0);
    write(2'd1, 8'h09, 8'h00, 8'h00, 7'b0000010, 1'b1);
    tick(8'h09, 8'h00, 8'h00, 3'd3);
    expect_out("mask_block", 4'b0000, 4'b0000, 2'd0, 1'b0);
    tick(8'h09, 8'h00, 8'h00, 3'd1);
    expect_out("mask_pass", 4'b0010, 4'b0000, 2'd1, 1'b0);
    write(2'd1, 8'h09, 8'h00, 8'h00, 7'h7F, 1'b0);
    expect_out("wr_disarm", 4'b0000, 4'b0000, 2'd0, 1'b0);
    tick(8'h09, 8'h00, 8'h00, 3'd1);
    expect_out("idle_no_ring", 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Reset with one slot ringing and two snoozed.
    write(2'd1, 8'h09, 8'h00, 8'h00, 7'h7F, 1'b1);
    tick(8'h12, 8'h00, 8'h00, 3'd0);
    expect_out("pre_rst_ring", 4'b1001, 4'b0000, 2'd0, 1'b0);
    set_btn(1'b0, 1'b1);
    expect_out("pre_rst_snz", 4'b0000, 4'b1001, 2'd0, 1'b0);
    set_btn(1'b0, 1'b0);
    tick(8'h09, 8'h00, 8'h00, 3'd1);
    expect_out("mixed", 4'b0010, 4'b1001, 2'd1, 1'b0);
    @(negedge clk);
    clk1sec = 1'b0; rst = 1'b0;
    expect_out("rst_mid", 4'b0000, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick(8'h12, 8'h00, 8'h00, 3'd0);
    expect_out("post_rst_12", 4'b0000, 4'b0000, 2'd0, 1'b0);
    tick(8'h09, 8'h00, 8'h00, 3'd1);
    expect_out("post_rst_09", 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Repeated snoozes on slot 0.
    write(2'd0, 8'h10, 8'h00, 8'h00, 7'h7F, 1'b1);
    tick(8'h10, 8'h00, 8'h00, 3'd0);
    expect_out("cap_ring", 4'b0001, 4'b0000, 2'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      set_btn(1'b0, 1'b1);
`ifdef ALARM_SNOOZE_CAP_EN
      if (k == 4) expect_out("snz_capped", 4'b0000, 4'b0000, 2'd0, 1'b0);
      else        expect_out($sformatf("snz%0d", k), 4'b0000, 4'b0001, 2'd0, 1'b0);
`else
      expect_out($sformatf("snz%0d", k), 4'b0000, 4'b0001, 2'd0, 1'b0);
`endif
      set_btn(1'b0, 1'b0);
`ifdef ALARM_SNOOZE_CAP_EN
      if (k < 4) begin
`endif
        for (int i = 1; i <= 300; i++) begin
          quiet_tick();
          if (i == 300) expect_out($sformatf("rering%0d", k), 4'b0001, 4'b0000, 2'd0, 1'b0);
        end
`ifdef ALARM_SNOOZE_CAP_EN
      end
`endif
    end
`ifdef ALARM_SNOOZE_CAP_EN
    tick(8'h10, 8'h00, 8'h00, 3'd0);
    expect_out("cap_armed", 4'b0001, 4'b0000, 2'd0, 1'b0);
`endif
    set_btn(1'b1, 1'b0);
    expect_out("final_ack", 4'b0000, 4'b0000, 2'd0, 1'b0);
    set_btn(1'b0, 1'b0);
    idle();
    idle();
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
